// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN resolves divide-by-zero and signed overflow at accept (1-cycle latency).
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [4:0]      i_rd_addr,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd_addr
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_div;
  logic            r_is_rem;
  logic            r_neg;
  logic            r_ovf;

  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_neg_in;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_rs1_data[XLEN-1];
  assign w_b_neg  = w_signed & i_rs2_data[XLEN-1];
  assign w_b_zero = (i_rs2_data == '0);
  assign w_ovf    = w_signed & (i_rs1_data == MIN_NEG) & (i_rs2_data == '1);
  assign w_abs_a  = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_abs_b  = w_b_neg ? -i_rs2_data : i_rs2_data;
  // Zero divisor leaves the all-ones quotient unsigned; remainder negation restores the dividend.
  assign w_neg_in = i_op[1] ? w_a_neg : ((w_a_neg ^ w_b_neg) & ~w_b_zero);

`ifdef DIV_EARLY_OUT_EN
  logic [XLEN-1:0] w_special;
  assign w_special = w_b_zero ? (i_op[1] ? i_rs1_data : '1)
                              : (i_op[1] ? '0 : MIN_NEG);
`endif

  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_lt;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quot_nx;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_fin;

  assign w_shift   = {r_rem, r_quot[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_lt      = w_diff[XLEN];
  assign w_rem_nx  = w_lt ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quot_nx = {r_quot[XLEN-2:0], ~w_lt};
  assign w_raw     = r_is_rem ? w_rem_nx : w_quot_nx;
  assign w_fin     = r_ovf ? (r_is_rem ? '0 : MIN_NEG)
                           : (r_neg ? -w_raw : w_raw);

  assign o_ready = (r_state == S_IDLE);
  assign o_busy  = (r_state == S_CALC) || (r_state == S_DONE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_is_rem  <= 1'b0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_rd_addr <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_flush) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_valid) begin
              o_rd_addr <= i_rd_addr;
              r_is_rem  <= i_op[1];
              r_neg     <= w_neg_in;
              r_ovf     <= w_ovf;
              r_div     <= w_abs_b;
              r_quot    <= w_abs_a;
              r_rem     <= '0;
              r_cnt     <= CW'(XLEN);
              r_state   <= S_CALC;
`ifdef DIV_EARLY_OUT_EN
              if (w_b_zero || w_ovf) begin
                o_result <= w_special;
                o_valid  <= 1'b1;
                r_cnt    <= '0;
                r_state  <= S_DONE;
              end
`endif
            end
          end
          S_CALC: begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              o_result <= w_fin;
              o_valid  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; special-case latency follows DIV_EARLY_OUT_EN.
module tb_div_unit;

  localparam int XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int SPECIAL_EDGES = 0;
`else
  localparam int SPECIAL_EDGES = 32;
`endif
  localparam int NORMAL_EDGES = 32;

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_valid = 1'b0;
  logic [1:0]      i_op = 2'b00;
  logic [XLEN-1:0] i_rs1_data = '0;
  logic [XLEN-1:0] i_rs2_data = '0;
  logic [4:0]      i_rd_addr = '0;
  logic            i_flush = 1'b0;
  logic            o_ready;
  logic            o_busy;
  logic            o_valid;
  logic [XLEN-1:0] o_result;
  logic [4:0]      o_rd_addr;

  int checks = 0;
  int errors = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (i_valid),
    .i_op       (i_op),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_rd_addr  (i_rd_addr),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_rd_addr  (o_rd_addr)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
    $fatal(1);
  end

  task automatic test_reset();
    #3;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", o_result); end
    checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", o_rd_addr); end
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", o_ready); end
  endtask

  // Accepts one request and checks edges-to-valid, result, rd and one-cycle strobe.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_edges);
    int n;
    @(negedge i_clk);
    n = 0;
    while (!o_ready && n < 100) begin @(negedge i_clk); n++; end
    i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    n = 0;
    while (!o_valid && n < 100) begin @(posedge i_clk); #1; n++; end
    checks++; if (n != exp_edges) begin errors++; $display("FAIL %s latency: got %0d edges want %0d", name, n, exp_edges); end
    checks++; if (o_result !== exp) begin errors++; $display("FAIL %s result: got %h want %h", name, o_result, exp); end
    checks++; if (o_rd_addr !== rd) begin errors++; $display("FAIL %s rd: got %0d want %0d", name, o_rd_addr, rd); end
    @(posedge i_clk);
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL %s strobe: got %b want 0", name, o_valid); end
  endtask

  task automatic test_signed();
    run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, NORMAL_EDGES);
    run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, NORMAL_EDGES);
    run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'hFFFF_FFFD, NORMAL_EDGES);
    run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'd1, NORMAL_EDGES);
  endtask

  task automatic test_unsigned();
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd1, 32'hFFFF_FFFF, NORMAL_EDGES);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd2, 32'd2, NORMAL_EDGES);
    run_op("divu_3_10", 2'b01, 32'd3, 32'd10, 5'd31, 32'd0, NORMAL_EDGES);
  endtask

  task automatic test_special();
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, SPECIAL_EDGES);
    run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 5'd12, 32'd5, SPECIAL_EDGES);
    run_op("rem_m7_0", 2'b10, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFF9, SPECIAL_EDGES);
    run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, SPECIAL_EDGES);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, SPECIAL_EDGES);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, SPECIAL_EDGES);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    int stray;
    run_op("pre_flush", 2'b01, 32'd90, 32'd9, 5'd4, 32'd10, NORMAL_EDGES);
    prev = o_result;
    @(negedge i_clk);
    i_op = 2'b01; i_rs1_data = 32'd100; i_rs2_data = 32'd7; i_rd_addr = 5'd3; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (10) @(posedge i_clk);
    #1 i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_valid); end
    checks++; if (o_result !== prev) begin errors++; $display("FAIL flush_result: got %h want %h", o_result, prev); end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL flush_stray: got %0d strobes want 0", stray); end
    run_op("post_flush", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14, NORMAL_EDGES);
  endtask

  task automatic test_async_reset();
    int stray;
    @(negedge i_clk);
    i_op = 2'b00; i_rs1_data = 32'hFFFF_FFF9; i_rs2_data = 32'd2; i_rd_addr = 5'd5; i_valid = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", o_valid); end
    checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL rst_mid_result: got %h want 0", o_result); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", o_ready); end
    checks++; if (o_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_mid_rd: got %0d want 0", o_rd_addr); end
    @(negedge i_clk);
    i_reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge i_clk); #1;
      if (o_valid) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray: got %0d strobes want 0", stray); end
  endtask

  task automatic test_back_to_back();
    int first, second, idle, valids, n;
    first = -1; second = -1; idle = 0; valids = 0;
    for (int e = 0; e < 80 && second < 0; e++) begin
      @(negedge i_clk);
      if (e == 0) begin
        i_op = 2'b01; i_rs1_data = 32'd100; i_rs2_data = 32'd7; i_rd_addr = 5'd7; i_valid = 1'b1;
      end
      if (first >= 0 && o_valid) begin
        valids++;
        checks++; if (o_result !== 32'd14) begin errors++; $display("FAIL b2b_result1: got %h want %h", o_result, 32'd14); end
      end
      if (first >= 0 && e > first && !o_busy) idle++;
      if (o_ready) begin
        if (first < 0) first = e;
        else second = e;
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    checks++; if (second - first != XLEN + 2) begin errors++; $display("FAIL b2b_spacing: got %0d edges want %0d", second - first, XLEN + 2); end
    checks++; if (idle != 1) begin errors++; $display("FAIL b2b_idle: got %0d idle cycles want 1", idle); end
    checks++; if (valids != 1) begin errors++; $display("FAIL b2b_strobes: got %0d want 1", valids); end
    n = 0;
    while (!o_valid && n < 100) begin @(negedge i_clk); n++; end
    checks++; if (o_valid !== 1'b1 || o_result !== 32'd14) begin errors++; $display("FAIL b2b_result2: got valid %b result %h want valid 1 result %h", o_valid, o_result, 32'd14); end
    @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_special();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
